// File: rtl/alu_sequencer_if.sv
// Command, ALU and response signals of the ALU sequencer.
// master = front-end/ALU/consumer side, slave = the sequencer.
interface alu_sequencer_if #(
  parameter int N = 8
);
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [3:0]   cmd_op_i;
  logic [N-1:0] cmd_a_i;
  logic [N-1:0] cmd_b_i;
  logic         cmd_use_acc_i;
  logic [N-1:0] alu_a_o;
  logic [N-1:0] alu_b_o;
  logic [3:0]   alu_ctrl_o;
  logic [N-1:0] alu_result_i;
  logic [3:0]   alu_flags_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [N-1:0] rsp_result_o;
  logic [3:0]   rsp_flags_o;
  logic         rsp_err_o;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_use_acc_i,
    output alu_result_i, alu_flags_i, rsp_ready_i,
    input  cmd_ready_o, alu_a_o, alu_b_o, alu_ctrl_o,
    input  rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_use_acc_i,
    input  alu_result_i, alu_flags_i, rsp_ready_i,
    output cmd_ready_o, alu_a_o, alu_b_o, alu_ctrl_o,
    output rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_err_o
  );
endinterface

// File: rtl/alu_sequencer.sv
// Drives an external ALU for SETTLE cycles per command, captures result/flags,
// and keeps a running accumulator usable as operand A of the next command.
module alu_sequencer #(
  parameter int N      = 8,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  logic [1:0]   state_reg, state_next;
  logic [3:0]   cnt_reg;
  logic [N-1:0] alu_a_reg, alu_b_reg, acc_reg, rsp_result_reg;
  logic [3:0]   alu_ctrl_reg, rsp_flags_reg;
  logic         rsp_err_reg;
  logic         op_legal, accept, capture;

  assign op_legal = (bus.cmd_op_i <= 4'd9);
  assign accept   = (state_reg == ST_IDLE) && bus.cmd_valid_i;
  // Capture on the last settle cycle so the response appears SETTLE+1 after accept.
  assign capture  = (state_reg == ST_DRIVE) && (cnt_reg == 4'd1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = op_legal ? ST_DRIVE : ST_RESP;
      ST_DRIVE: if (capture) state_next = ST_RESP;
      ST_RESP:  if (bus.rsp_ready_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_ctrl_reg   <= '0;
      acc_reg        <= '0;
      rsp_result_reg <= '0;
      rsp_flags_reg  <= '0;
      rsp_err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept && op_legal) begin
        alu_a_reg    <= bus.cmd_use_acc_i ? acc_reg : bus.cmd_a_i;
        alu_b_reg    <= bus.cmd_b_i;
        alu_ctrl_reg <= bus.cmd_op_i;
        cnt_reg      <= SETTLE_CNT;
      end else if (accept) begin
        // Illegal opcode: answer immediately with an error, ALU untouched.
        rsp_result_reg <= '0;
        rsp_flags_reg  <= '0;
        rsp_err_reg    <= 1'b1;
      end
      if (state_reg == ST_DRIVE) begin
        cnt_reg <= cnt_reg - 4'd1;
        if (capture) begin
          rsp_result_reg <= bus.alu_result_i;
          acc_reg        <= bus.alu_result_i;
          rsp_flags_reg  <= bus.alu_flags_i;
          rsp_err_reg    <= 1'b0;
        end
      end
    end
  end

  assign bus.cmd_ready_o  = (state_reg == ST_IDLE);
  assign bus.rsp_valid_o  = (state_reg == ST_RESP);
  assign bus.alu_a_o      = alu_a_reg;
  assign bus.alu_b_o      = alu_b_reg;
  assign bus.alu_ctrl_o   = alu_ctrl_reg;
  assign bus.rsp_result_o = rsp_result_reg;
  assign bus.rsp_flags_o  = rsp_flags_reg;
  assign bus.rsp_err_o    = rsp_err_reg;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + random bench for alu_sequencer: two instances (SETTLE=1 and 4)
// share one stimulus driver, selected by sel; the bench itself plays the ALU.
module tb_alu_sequencer;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       sel = 1'b0;
  logic       d_cmd_valid = 1'b0;
  logic [3:0] d_op = 4'd0;
  logic [7:0] d_a = 8'd0, d_b = 8'd0;
  logic       d_use_acc = 1'b0;
  logic       d_rsp_ready = 1'b0;

  alu_sequencer_if #(.N(N)) if1 ();
  alu_sequencer_if #(.N(N)) if4 ();

  alu_sequencer #(.N(N), .SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  alu_sequencer #(.N(N), .SETTLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  // Reference ALU: {C,N,V,Z, result}. Shifts use b[2:0] as the amount.
  function automatic logic [11:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] r;
    logic c, v;
    int sh;
    t = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
    sh = int'(b[2:0]);
    case (op)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin r = a - b; c = (a >= b);
                  v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~a;
      4'd5: r = a ^ b;
      4'd6, 4'd7: begin r = a << sh; c = (sh != 0) ? a[8 - sh] : 1'b0; end
      4'd8: begin r = a >> sh; c = (sh != 0) ? a[sh - 1] : 1'b0; end
      4'd9: begin r = 8'($signed(a) >>> sh); c = (sh != 0) ? a[sh - 1] : 1'b0; end
      default: r = 8'd0;
    endcase
    return {c, r[7], v, (r == 8'd0), r};
  endfunction

  assign if1.cmd_valid_i = d_cmd_valid & ~sel;
  assign if4.cmd_valid_i = d_cmd_valid & sel;
  assign if1.cmd_op_i = d_op;      assign if4.cmd_op_i = d_op;
  assign if1.cmd_a_i = d_a;        assign if4.cmd_a_i = d_a;
  assign if1.cmd_b_i = d_b;        assign if4.cmd_b_i = d_b;
  assign if1.cmd_use_acc_i = d_use_acc;  assign if4.cmd_use_acc_i = d_use_acc;
  assign if1.rsp_ready_i = d_rsp_ready;  assign if4.rsp_ready_i = d_rsp_ready;
  assign {if1.alu_flags_i, if1.alu_result_i} = ref_alu(if1.alu_ctrl_o, if1.alu_a_o, if1.alu_b_o);
  assign {if4.alu_flags_i, if4.alu_result_i} = ref_alu(if4.alu_ctrl_o, if4.alu_a_o, if4.alu_b_o);

  logic       o_ready, o_valid, o_err;
  logic [7:0] o_alu_a, o_alu_b, o_result;
  logic [3:0] o_ctrl, o_flags;
  assign o_ready  = sel ? if4.cmd_ready_o  : if1.cmd_ready_o;
  assign o_valid  = sel ? if4.rsp_valid_o  : if1.rsp_valid_o;
  assign o_err    = sel ? if4.rsp_err_o    : if1.rsp_err_o;
  assign o_alu_a  = sel ? if4.alu_a_o      : if1.alu_a_o;
  assign o_alu_b  = sel ? if4.alu_b_o      : if1.alu_b_o;
  assign o_ctrl   = sel ? if4.alu_ctrl_o   : if1.alu_ctrl_o;
  assign o_result = sel ? if4.rsp_result_o : if1.rsp_result_o;
  assign o_flags  = sel ? if4.rsp_flags_o  : if1.rsp_flags_o;

  // Sequencer model: accumulator and last legal ALU drive per instance.
  logic [7:0] acc_m [2];
  logic [7:0] last_a [2], last_b [2];
  logic [3:0] last_ctrl [2];
  logic [7:0] exp_res;
  logic [3:0] exp_flags;
  logic       exp_err;
  int         exp_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_alu_a"}, 32'(o_alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(o_alu_b), 32'd0);
    chk({tag, "_ctrl"}, 32'(o_ctrl), 32'd0);
    chk({tag, "_result"}, 32'(o_result), 32'd0);
    chk({tag, "_flags"}, 32'(o_flags), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
  endtask

  // Present a command until accepted; c = cycle index of the accept cycle.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic use_acc, output int c);
    int s;
    logic [7:0] opa;
    bit ok;
    s = sel ? 1 : 0;
    ok = 0;
    c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      d_op = op; d_a = a; d_b = b; d_use_acc = use_acc; d_cmd_valid = 1'b1;
      if (o_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    c = cyc;
    @(posedge clk);
    #1 d_cmd_valid = 1'b0;
    opa = use_acc ? acc_m[s] : a;
    if (op <= 4'd9) begin
      {exp_flags, exp_res} = ref_alu(op, opa, b);
      exp_err = 1'b0;
      exp_lat = (s == 1 ? 4 : 1) + 1;
      acc_m[s] = exp_res;
      last_a[s] = opa; last_b[s] = b; last_ctrl[s] = op;
    end else begin
      exp_res = 8'd0; exp_flags = 4'd0; exp_err = 1'b1; exp_lat = 1;
    end
  endtask

  task automatic collect(input string tag, input int c);
    int s;
    bit ok;
    s = sel ? 1 : 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (o_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    chk({tag, "_latency"}, 32'(cyc - c), 32'(exp_lat));
    chk({tag, "_result"}, 32'(o_result), 32'(exp_res));
    chk({tag, "_flags"}, 32'(o_flags), 32'(exp_flags));
    chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
    chk({tag, "_alu_a"}, 32'(o_alu_a), 32'(last_a[s]));
    chk({tag, "_alu_b"}, 32'(o_alu_b), 32'(last_b[s]));
    chk({tag, "_ctrl"}, 32'(o_ctrl), 32'(last_ctrl[s]));
    $display("txn %s: op=%0d a=%02h b=%02h acc=%0b -> result=%02h flags=%04b err=%0b lat=%0d",
             tag, d_op, d_a, d_b, d_use_acc, o_result, o_flags, o_err, cyc - c);
  endtask

  initial begin
    int c, prev_c;
    logic [3:0] rop;
    logic [7:0] held;
    for (int i = 0; i < 2; i++) begin
      acc_m[i] = 8'd0; last_a[i] = 8'd0; last_b[i] = 8'd0; last_ctrl[i] = 4'd0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset1");
    sel = 1'b1; #1;
    check_reset("reset4");
    sel = 1'b0; #1;
    d_rsp_ready = 1'b1;

    // 1: ADD wrap-around
    issue(4'd0, 8'hFF, 8'h01, 1'b0, c);
    collect("t1_add", c);
    chk("t1_C", 32'(o_flags[3]), 32'd1);
    chk("t1_N", 32'(o_flags[2]), 32'd0);
    chk("t1_Z", 32'(o_flags[0]), 32'd1);

    // 2: chain through the accumulator
    issue(4'd0, 8'h10, 8'h05, 1'b0, c);
    collect("t2_add", c);
    chk("t2_add_val", 32'(o_result), 32'h15);
    issue(4'd5, 8'hAA, 8'h0F, 1'b1, c);
    @(negedge clk);
    chk("t2_drive_a", 32'(o_alu_a), 32'h15);
    collect("t2_xor", c);
    chk("t2_xor_val", 32'(o_result), 32'h1A);

    // 3: illegal opcode, then confirm accumulator untouched
    issue(4'd12, 8'h33, 8'h00, 1'b0, c);
    collect("t3_illegal", c);
    issue(4'd0, 8'h00, 8'h00, 1'b1, c);
    collect("t3_acc", c);
    chk("t3_acc_val", 32'(o_result), 32'h1A);

    // 4: SETTLE=4 with response back-pressure and an ignored command pulse
    sel = 1'b1; #1;
    d_rsp_ready = 1'b0;
    issue(4'd1, 8'h50, 8'h20, 1'b0, c);
    collect("t4_sub", c);
    held = o_result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d_cmd_valid = (i == 4);
      d_op = 4'd0;
      chk("t4_hold_valid", 32'(o_valid), 32'd1);
      chk("t4_hold_result", 32'(o_result), 32'(held));
      chk("t4_hold_ready", 32'(o_ready), 32'd0);
    end
    @(negedge clk);
    d_cmd_valid = 1'b0;
    d_rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_after_valid", 32'(o_valid), 32'd0);
    chk("t4_after_ready", 32'(o_ready), 32'd1);
    chk("t4_after_ctrl", 32'(o_ctrl), 32'd1);
    chk("t4_after_a", 32'(o_alu_a), 32'h50);
    sel = 1'b0; #1;

    // 5: reset during DRIVE discards the response and clears the accumulator
    issue(4'd9, 8'h80, 8'h01, 1'b0, c);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    acc_m[0] = 8'd0; last_a[0] = 8'd0; last_b[0] = 8'd0; last_ctrl[0] = 4'd0;
    @(negedge clk);
    check_reset("t5_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(o_valid), 32'd0);
    end
    issue(4'd0, 8'h77, 8'h00, 1'b1, c);
    collect("t5_acc", c);
    chk("t5_acc_zero", 32'(o_result), 32'd0);
    chk("t5_Z", 32'(o_flags[0]), 32'd1);

    // 6: random back-to-back stream, ready tied high
    prev_c = -1;
    for (int i = 0; i < 20; i++) begin
      rop = 4'($urandom_range(0, 9));
      issue(rop, 8'($urandom), 8'($urandom), 1'($urandom), c);
      if (prev_c >= 0) chk("t6_spacing", 32'(c - prev_c), 32'd3);
      collect("t6_rand", c);
      prev_c = c;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
